// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - digit-serial ripple-borrow subtractor; optional ovf port via SERIAL_SUB_OVF_EN
module serial_subtractor #(
    parameter int SIZE  = 8,
    parameter int DIGIT = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    input  logic            bin,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SIZE-1:0] diff,
    output logic            bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic            ovf
`endif
);

    localparam int N  = SIZE / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]      state;
    logic [CW-1:0]   cnt;
    logic            brw;
    // a_sh doubles as the result register: each digit of the difference
    // enters at the top as the consumed minuend digit leaves the bottom.
    logic [SIZE-1:0] a_sh;
    logic [SIZE-1:0] b_sh;
    logic [SIZE-1:0] a_next;
    logic [DIGIT:0]  step;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // One digit of subtraction with the registered borrow; MSB is borrow-out.
    assign step = {1'b0, a_sh[DIGIT-1:0]} - {1'b0, b_sh[DIGIT-1:0]} - {{DIGIT{1'b0}}, brw};

    generate
        if (DIGIT == SIZE) begin : g_single
            assign a_next = step[DIGIT-1:0];
        end else begin : g_multi
            assign a_next = {step[DIGIT-1:0], a_sh[SIZE-1:DIGIT]};
        end
    endgenerate

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb;
    logic b_msb;

    // Operand sign bits are captured at accept since the shift registers lose them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ovf   <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            a_msb <= a[SIZE-1];
            b_msb <= b[SIZE-1];
        end else if (state == RUN && cnt == LAST) begin
            ovf <= (a_msb != b_msb) && (a_next[SIZE-1] != a_msb);
        end
    end
`endif

    // Control FSM, digit counter and the shifting datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            brw   <= 1'b0;
            a_sh  <= '0;
            b_sh  <= '0;
            diff  <= '0;
            bout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        brw   <= bin;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sh <= a_next;
                    b_sh <= b_sh >> DIGIT;
                    brw  <= step[DIGIT];
                    if (cnt == LAST) begin
                        diff  <= a_next;
                        bout  <= step[DIGIT];
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - randomized self-checking bench for serial_subtractor
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] in_valid;
    logic [2:0] in_ready;
    logic [2:0] out_valid;
    logic [2:0] bout;
    logic [2:0] ovf;
    logic [7:0] diff [3];
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic       out_ready;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_diff;

    always #5 clk = ~clk;

    serial_subtractor #(.SIZE(8), .DIGIT(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a), .b(b), .bin(bin), .out_valid(out_valid[0]), .out_ready(out_ready),
        .diff(diff[0]), .bout(bout[0])
`ifdef SERIAL_SUB_OVF_EN
        , .ovf(ovf[0])
`endif
    );

    serial_subtractor #(.SIZE(8), .DIGIT(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a), .b(b), .bin(bin), .out_valid(out_valid[1]), .out_ready(out_ready),
        .diff(diff[1]), .bout(bout[1])
`ifdef SERIAL_SUB_OVF_EN
        , .ovf(ovf[1])
`endif
    );

    serial_subtractor #(.SIZE(8), .DIGIT(8)) u_d8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .a(a), .b(b), .bin(bin), .out_valid(out_valid[2]), .out_ready(out_ready),
        .diff(diff[2]), .bout(bout[2])
`ifdef SERIAL_SUB_OVF_EN
        , .ovf(ovf[2])
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Issue one operation to unit k and check latency and results against plain arithmetic.
    task automatic do_op(input int k, input logic [7:0] av, input logic [7:0] bv,
                         input logic bi, input bit toggle);
        int n;
        int cyc;
        int full;
        logic exp_bout;
        logic exp_ovf;
        n = (k == 0) ? 8 : (k == 1) ? 2 : 1;
        @(negedge clk);
        a = av; b = bv; bin = bi; in_valid[k] = 1'b1;
        chk($sformatf("in_ready_idle_u%0d", k), in_ready[k], 1);
        @(posedge clk); #1;
        in_valid[k] = 1'b0;
        cyc = 0;
        while (!out_valid[k] && cyc < 40) begin
            chk($sformatf("in_ready_run_u%0d", k), in_ready[k], 0);
            if (toggle) begin
                a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk($sformatf("latency_u%0d", k), cyc, n);
        full     = int'(av) - int'(bv) - int'(bi);
        exp_diff = 8'(full);
        exp_bout = (full < 0);
        exp_ovf  = (av[7] != bv[7]) && (exp_diff[7] != av[7]);
        chk($sformatf("diff_u%0d_%0d-%0d-%0d", k, av, bv, bi), diff[k], exp_diff);
        chk($sformatf("bout_u%0d_%0d-%0d-%0d", k, av, bv, bi), bout[k], exp_bout);
`ifdef SERIAL_SUB_OVF_EN
        chk($sformatf("ovf_u%0d_%0d-%0d-%0d", k, av, bv, bi), ovf[k], exp_ovf);
`else
        if (exp_ovf) begin end
`endif
        if (out_ready) begin
            @(posedge clk); #1;
            chk($sformatf("handoff_in_ready_u%0d", k), in_ready[k], 1);
            chk($sformatf("handoff_out_valid_u%0d", k), out_valid[k], 0);
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = '0; a = '0; b = '0; bin = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_in_ready_u%0d", k), in_ready[k], 1);
            chk($sformatf("rst_out_valid_u%0d", k), out_valid[k], 0);
            chk($sformatf("rst_diff_u%0d", k), diff[k], 0);
            chk($sformatf("rst_bout_u%0d", k), bout[k], 0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases.
        do_op(0, 8'd200, 8'd55, 1'b0, 1'b0);
        do_op(0, 8'd5, 8'd9, 1'b0, 1'b0);
        do_op(0, 8'd0, 8'd0, 1'b1, 1'b0);
        do_op(1, 8'h80, 8'h01, 1'b0, 1'b0);
        do_op(1, 8'h10, 8'h01, 1'b0, 1'b0);
        do_op(2, 8'd255, 8'd255, 1'b1, 1'b0);

        // Backpressure with operand toggling during RUN.
        out_ready = 1'b0;
        do_op(0, 8'd77, 8'd140, 1'b1, 1'b1);
        repeat (5) begin
            @(posedge clk); #1;
            chk("bp_out_valid", out_valid[0], 1);
            chk("bp_in_ready", in_ready[0], 0);
            chk("bp_diff_stable", diff[0], exp_diff);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_out_valid", out_valid[0], 0);
        chk("bp_release_in_ready", in_ready[0], 1);

        // Asynchronous reset in the middle of an 8-cycle operation.
        @(negedge clk);
        a = 8'd99; b = 8'd33; bin = 1'b0; in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", in_ready[0], 1);
        chk("midrst_out_valid", out_valid[0], 0);
        chk("midrst_diff", diff[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(0, 8'd10, 8'd3, 1'b0, 1'b0);

        // Randomized operations across all three digit widths.
        for (int i = 0; i < 30; i++) begin
            do_op(i % 3, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

- Multi-cycle ripple-borrow subtractor: computes `diff = a - b - bin` over `SIZE` bits, processing `DIGIT` bits per clock cycle.
- Borrow ripples from one digit to the next through a registered borrow flop.
- Sits in the arithmetic library beside the combinational full-adder chain and serves the opposite operation, trading latency for area.
- Valid/ready handshake on both sides lets it hang off any datapath stage.

## Interface
- `SIZE`, default 8: operand and result width in bits. Must be ≥2 and a multiple of `DIGIT`.
- `DIGIT`, default 1: bits processed per cycle. 1 gives a fully bit-serial unit; `SIZE` gives a single-cycle compute.
- `clk`  input  1: clock; all state updates on the rising edge.
- `rst_n`  input  1: reset, asynchronous and active-low.
- `in_valid`  input  1: operands present.
- `in_ready`  output  1: unit can accept operands.
- `a`  input  SIZE: minuend.
- `b`  input  SIZE: subtrahend.
- `bin`  input  1: borrow-in.
- `out_valid`  output  1: result present.
- `out_ready`  input  1: consumer takes result.
- `diff`  output  SIZE: `(a - b - bin) mod 2^SIZE`.
- `bout`  output  1: borrow-out; 1 iff `a < b + bin` (unsigned).
- `ovf`  output  1: signed two's-complement overflow. Present only with `SERIAL_SUB_OVF_EN`.

## Operation
- States: IDLE, RUN, DONE. `N = SIZE/DIGIT`.
- **IDLE**
  - `in_ready=1`, `out_valid=0`.
  - On `in_valid & in_ready`: latch `a`, `b` into shift registers, load the borrow flop with `bin`, clear the digit counter, go to RUN.
- **RUN**
  - `in_ready=0`.
  - Each cycle, take the low `DIGIT` bits of `a` and `b` and compute `{brw, d} = a_dig - b_dig - borrow` at `DIGIT+1` bits.
  - Shift `d` into the result register from the MSB side. Shift both operand registers right by `DIGIT`. Store `brw` in the borrow flop.
  - After the Nth digit, go to DONE.
  - Input changes during RUN are ignored.
- **DONE**
  - `out_valid=1`; `diff`, `bout` (and `ovf`) are stable.
  - On `out_ready`, go to IDLE.
  - `in_ready=0` in DONE, so there is no accept on the same edge as the result handoff.
- `bout` equals the final borrow flop value.
- `ovf = (a[SIZE-1] != b[SIZE-1]) & (diff[SIZE-1] != a[SIZE-1])`, using the latched original `a` and `b` MSBs. The sign bits are captured at accept, because the operand registers are shifted.
- `diff`, `bout` and `ovf` outside DONE hold their previous value. They are don't-care to the consumer.
- Reset, asynchronous, at any time including mid-RUN or DONE:
  - state returns to IDLE;
  - `in_ready=1`, `out_valid=0`;
  - `diff=0`, `bout=0`, `ovf=0`, counter 0.
  - The in-flight operation is discarded.

## Timing
- Acceptance edge E0.
- RUN covers edges E1..EN.
- `out_valid` rises after EN, so the result is visible N cycles after the acceptance edge.
- With `out_ready` held high, the DONE→IDLE transition occurs at EN+1. `in_ready` is high again after EN+1.
- Minimum issue interval is N+2 cycles.
- `out_ready` low holds DONE indefinitely, with outputs frozen.
- `DIGIT=SIZE` gives N=1: result valid one cycle after accept.

## Configuration
- Macro: `SERIAL_SUB_OVF_EN`.
- **Defined:** the `ovf` port exists, plus the sign-capture flops.
- **Undefined:** the `ovf` port and its logic are absent. All other behaviour and timing are identical.

## Test plan
Operands are written `a - b - bin` with `bin=0` unless stated.

- **Basic subtract.** `SIZE=8`, `DIGIT=1`, `200 - 55` → after 8 cycles `out_valid=1`, `diff=145`, `bout=0`.
- **Wrap-around.** `SIZE=8`, `DIGIT=1`, `5 - 9` → `diff=252`, `bout=1`. Then `0 - 0` with `bin=1` → `diff=255`, `bout=1`.
- **Signed overflow** (`SERIAL_SUB_OVF_EN` defined). `SIZE=8`, `DIGIT=4`, `0x80 - 0x01` → after 2 cycles `diff=0x7F`, `ovf=1`, `bout=0`. Then `0x10 - 0x01` → `diff=0x0F`, `ovf=0`.
- **Backpressure.**
  - Complete an op with `out_ready=0` for 5 cycles → `out_valid` stays 1 with `diff` stable, and `in_ready=0` throughout.
  - Raise `out_ready` → IDLE next cycle.
  - Toggling `a`/`b` during RUN does not change the result.
- **Reset mid-run.**
  - Assert `rst_n=0` asynchronously at cycle 3 of an 8-cycle op → `in_ready=1`, `out_valid=0`, `diff=0` immediately.
  - After release, a new op `10 - 3` → `diff=7`, `bout=0`.
- **Single-cycle mode.** `DIGIT=SIZE=8`, `255 - 255` with `bin=1` → `out_valid` one cycle after accept, `diff=255`, `bout=1`.
